// File: rtl/lsu_mem_responder_pkg.sv
// lsu_mem_responder_pkg
// Shared types for the LSU data-memory responder: data and address widths,
// the responder FSM state encoding and a small index-width helper.
package lsu_mem_responder_pkg;

  typedef logic [15:0] data_t;
  typedef logic [7:0]  data_memory_address_t;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    READ_WAITING  = 2'd1,
    WRITE_WAITING = 2'd2,
    RELAYING      = 2'd3
  } mem_resp_state_t;

  // Width of an index into n channels; never zero so a single channel still
  // gets a legal 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lsu_mem_responder_rr_arbiter.sv
// rr_arbiter
// Round-robin request picker for the responder. Scans the request vector
// starting at the stored pointer, wrapping around, and reports the first
// requester. On an advance strobe with a valid grant the pointer moves to
// the slot after the granted one.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high; pointer returns to 0
//   req         in   [N] one request bit per channel
//   advance     in   1 when the current grant is being taken
//   grant_idx   out  index of the selected channel
//   grant_valid out  1 when any channel is requesting
module rr_arbiter
  import lsu_mem_responder_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] rr_next;

  always_comb begin
    int pos;
    grant_valid = 1'b0;
    grant_idx   = '0;
    pos         = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(rr_next) + k;
      if (pos >= N) pos = pos - N;
      if (!grant_valid && req[pos[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = pos[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_next <= '0;
    end else if (advance && grant_valid) begin
      rr_next <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder
// Responder side of the LSU data-memory handshake. Collects load/store
// requests from NUM_CONSUMERS LSUs, serves one at a time on the single
// external memory port in round-robin order, and returns a one-cycle ready
// pulse (plus load data) to the requesting LSU.
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   consumer_read_valid/address    per-LSU load request
//   consumer_read_ready/data       per-LSU load completion pulse and data
//   consumer_write_valid/address/data  per-LSU store request
//   consumer_write_ready           per-LSU store completion pulse
//   mem_read_valid/address         downstream read request
//   mem_read_ready/data            downstream read completion
//   mem_write_valid/address/data   downstream write request
//   mem_write_ready                downstream write completion
//
// state         | meaning
// --------------+-----------------------------------------------------------
// IDLE          | no transaction; pick next requester round-robin
// READ_WAITING  | mem_read_valid high, waiting for mem_read_ready
// WRITE_WAITING | mem_write_valid high, waiting for mem_write_ready
// RELAYING      | ready pulse issued; wait for served LSU to drop its valid
module lsu_mem_responder
  import lsu_mem_responder_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CONSUMERS-1:0]   consumer_read_valid,
  input  data_memory_address_t       consumer_read_address  [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]   consumer_read_ready,
  output data_t                      consumer_read_data     [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0]   consumer_write_valid,
  input  data_memory_address_t       consumer_write_address [NUM_CONSUMERS],
  input  data_t                      consumer_write_data    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]   consumer_write_ready,
  output logic                       mem_read_valid,
  output data_memory_address_t       mem_read_address,
  input  logic                       mem_read_ready,
  input  data_t                      mem_read_data,
  output logic                       mem_write_valid,
  output data_memory_address_t       mem_write_address,
  output data_t                      mem_write_data,
  input  logic                       mem_write_ready
);

  localparam int IDX_W = idx_width(NUM_CONSUMERS);

  mem_resp_state_t          state;
  logic [IDX_W-1:0]         current_consumer;
  // Remembers which kind of request is being relayed so RELAYING watches
  // the right valid; a consumer may still hold the other one.
  logic                     served_write;

  logic [NUM_CONSUMERS-1:0] req;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_valid;
  logic                     advance;

  assign req     = consumer_read_valid | consumer_write_valid;
  assign advance = (state == IDLE);

  rr_arbiter #(
    .N     (NUM_CONSUMERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .advance     (advance),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      current_consumer     <= '0;
      served_write         <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        consumer_read_data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            current_consumer <= grant_idx;
            // A consumer asserting both gets its read first; the write stays
            // pending and wins a later round-robin slot.
            if (consumer_read_valid[grant_idx]) begin
              served_write     <= 1'b0;
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[grant_idx];
              state            <= READ_WAITING;
            end else begin
              served_write      <= 1'b1;
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[grant_idx];
              mem_write_data    <= consumer_write_data[grant_idx];
              state             <= WRITE_WAITING;
            end
          end
        end

        READ_WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid                        <= 1'b0;
            consumer_read_data[current_consumer]  <= mem_read_data;
            consumer_read_ready[current_consumer] <= 1'b1;
            state                                 <= RELAYING;
          end
        end

        WRITE_WAITING: begin
          if (mem_write_ready) begin
            mem_write_valid                        <= 1'b0;
            consumer_write_ready[current_consumer] <= 1'b1;
            state                                  <= RELAYING;
          end
        end

        RELAYING: begin
          consumer_read_ready  <= '0;
          consumer_write_ready <= '0;
          if (served_write ? !consumer_write_valid[current_consumer]
                           : !consumer_read_valid[current_consumer]) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
module tb_lsu_mem_responder;
  import lsu_mem_responder_pkg::*;

  localparam int N = 4;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         rd_v;
  data_memory_address_t rd_a [N];
  logic [N-1:0]         c_rd_rdy;
  data_t                c_rd_data [N];
  logic [N-1:0]         wr_v;
  data_memory_address_t wr_a [N];
  data_t                wr_d [N];
  logic [N-1:0]         c_wr_rdy;
  logic                 mem_read_valid;
  data_memory_address_t mem_read_address;
  logic                 mem_read_ready;
  data_t                mem_read_data;
  logic                 mem_write_valid;
  data_memory_address_t mem_write_address;
  data_t                mem_write_data;
  logic                 mem_write_ready;

  lsu_mem_responder #(.NUM_CONSUMERS(N)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rd_v),
    .consumer_read_address  (rd_a),
    .consumer_read_ready    (c_rd_rdy),
    .consumer_read_data     (c_rd_data),
    .consumer_write_valid   (wr_v),
    .consumer_write_address (wr_a),
    .consumer_write_data    (wr_d),
    .consumer_write_ready   (c_wr_rdy),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_err = 0;
  int lat   = 0;
  int rcnt  = 0;
  int wcnt  = 0;

  data_t mem_arr [256];   // environment memory behind the port
  data_t mm [256];        // reference model view of memory
  data_t m_last [N];      // model: last load data per consumer
  int    m_rr = 0;        // model: next round-robin start
  int    obs_order[$];

  typedef struct {
    int    c;
    bit    w;
    data_t d;
  } exp_t;

  function automatic data_t init_val(input int i);
    if (i == 16) return 16'hBEEF;
    return data_t'(i * 997 + 12345);
  endfunction

  // Simple memory: acknowledges a request `lat` negedges after it is seen.
  initial begin
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = init_val(i);
    forever begin
      @(negedge clk);
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      if (mem_read_valid) begin
        if (rcnt >= lat) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem_arr[mem_read_address];
          rcnt = 0;
        end else rcnt++;
      end else rcnt = 0;
      if (mem_write_valid) begin
        if (wcnt >= lat) begin
          mem_write_ready = 1'b1;
          mem_arr[mem_write_address] = mem_write_data;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_rr = 0;
    for (int i = 0; i < N; i++) m_last[i] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " mem_rv"}, 32'(mem_read_valid), 0);
    chk({tag, " mem_ra"}, 32'(mem_read_address), 0);
    chk({tag, " mem_wv"}, 32'(mem_write_valid), 0);
    chk({tag, " mem_wa"}, 32'(mem_write_address), 0);
    chk({tag, " mem_wd"}, 32'(mem_write_data), 0);
    chk({tag, " rd_rdy"}, 32'(c_rd_rdy), 0);
    chk({tag, " wr_rdy"}, 32'(c_wr_rdy), 0);
    for (int i = 0; i < N; i++) chk({tag, " rd_data"}, 32'(c_rd_data[i]), 0);
    chk({tag, " state"}, 32'(dut.state), 32'(IDLE));
  endtask

  // Serves every request currently asserted, behaving as the LSUs (each
  // drops a valid the cycle after it sees its ready) and checking each
  // completion against the order and data the model predicts.
  task automatic run_round(input string tag);
    logic [N-1:0]   pr, pw, prev_r, prev_w;
    logic [2*N-1:0] ev;
    exp_t           q[$];
    exp_t           e;
    int             c, cyc;
    pr = rd_v;
    pw = wr_v;
    while ((pr | pw) != '0) begin
      c = m_rr;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (pr[c] || pw[c]) break;
      end
      e.c = c;
      if (pr[c]) begin
        e.w = 1'b0;
        e.d = mm[rd_a[c]];
        m_last[c] = e.d;
        pr[c] = 1'b0;
      end else begin
        e.w = 1'b1;
        e.d = wr_d[c];
        mm[wr_a[c]] = wr_d[c];
        pw[c] = 1'b0;
      end
      m_rr = (c + 1) % N;
      q.push_back(e);
    end
    obs_order.delete();
    prev_r = '0;
    prev_w = '0;
    cyc = 0;
    while (q.size() > 0 && cyc < 400) begin
      tick();
      cyc++;
      if ((prev_r | prev_w) != '0)
        chk({tag, " pulse_width"}, 32'((c_rd_rdy & prev_r) | (c_wr_rdy & prev_w)), 0);
      if ((c_rd_rdy | c_wr_rdy) != '0) begin
        e = q.pop_front();
        ev = '0;
        ev[e.w ? N + e.c : e.c] = 1'b1;
        chk({tag, " who"}, 32'({c_wr_rdy, c_rd_rdy}), 32'(ev));
        if (!e.w) chk({tag, " rd_data"}, 32'(c_rd_data[e.c]), 32'(e.d));
        for (int i = 0; i < N; i++) begin
          if (c_rd_rdy[i]) begin rd_v[i] = 1'b0; obs_order.push_back(i); end
          if (c_wr_rdy[i]) begin wr_v[i] = 1'b0; obs_order.push_back(i); end
        end
      end
      prev_r = c_rd_rdy;
      prev_w = c_wr_rdy;
    end
    chk({tag, " left"}, 32'(q.size()), 0);
    tick();
    chk({tag, " idle"}, 32'(dut.state), 32'(IDLE));
    chk({tag, " ready_off"}, 32'({c_wr_rdy, c_rd_rdy}), 0);
    for (int i = 0; i < N; i++) chk({tag, " held"}, 32'(c_rd_data[i]), 32'(m_last[i]));
  endtask

  initial begin
    reset = 1'b1;
    rd_v  = '0;
    wr_v  = '0;
    for (int i = 0; i < N; i++) begin
      rd_a[i]   = '0;
      wr_a[i]   = '0;
      wr_d[i]   = '0;
      m_last[i] = '0;
    end
    for (int i = 0; i < 256; i++) mm[i] = init_val(i);
    do_reset();
    check_all_zero("reset");

    // single load from consumer 2
    lat = 0;
    rd_a[2] = 8'h10;
    rd_v[2] = 1'b1;
    tick();
    chk("load grant", 32'(mem_read_valid), 1);
    chk("load addr", 32'(mem_read_address), 32'h10);
    chk("load state", 32'(dut.state), 32'(READ_WAITING));
    chk("load early_rdy", 32'(c_rd_rdy), 0);
    tick();
    chk("load rdy", 32'(c_rd_rdy), 32'b0100);
    chk("load data", 32'(c_rd_data[2]), 32'hBEEF);
    chk("load mem_rv_off", 32'(mem_read_valid), 0);
    m_last[2] = 16'hBEEF;
    m_rr = 3;
    rd_v[2] = 1'b0;
    tick();
    chk("load rdy_1cyc", 32'(c_rd_rdy), 0);
    chk("load idle", 32'(dut.state), 32'(IDLE));
    chk("load held", 32'(c_rd_data[2]), 32'hBEEF);

    // single store from consumer 0
    wr_a[0] = 8'h05;
    wr_d[0] = 16'h1234;
    wr_v[0] = 1'b1;
    tick();
    chk("store grant", 32'(mem_write_valid), 1);
    chk("store addr", 32'(mem_write_address), 32'h05);
    chk("store data", 32'(mem_write_data), 32'h1234);
    chk("store no_rv", 32'(mem_read_valid), 0);
    tick();
    chk("store rdy", 32'(c_wr_rdy), 32'b0001);
    chk("store no_rrdy", 32'(c_rd_rdy), 0);
    chk("store no_rv2", 32'(mem_read_valid), 0);
    mm[8'h05] = 16'h1234;
    m_rr = 1;
    wr_v[0] = 1'b0;
    tick();
    chk("store rdy_1cyc", 32'(c_wr_rdy), 0);
    chk("store idle", 32'(dut.state), 32'(IDLE));

    // round-robin: all four read at once, twice, from pointer 0
    do_reset();
    lat = 2;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        rd_a[i] = data_memory_address_t'(8'h40 + i);
        rd_v[i] = 1'b1;
      end
      run_round("rr");
      chk("rr count", 32'(obs_order.size()), 4);
      for (int i = 0; i < obs_order.size(); i++) chk("rr order", 32'(obs_order[i]), 32'(i));
    end

    // consumer 1 holds read valid 3 cycles past its ready pulse
    lat = 0;
    rd_a[1] = 8'h22;
    rd_v[1] = 1'b1;
    tick();
    chk("late grant", 32'(mem_read_valid), 1);
    tick();
    chk("late rdy", 32'(c_rd_rdy), 32'b0010);
    chk("late data", 32'(c_rd_data[1]), 32'(mm[8'h22]));
    m_last[1] = mm[8'h22];
    m_rr = 2;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("late relaying", 32'(dut.state), 32'(RELAYING));
      chk("late no_reissue", 32'(mem_read_valid), 0);
      chk("late no_rdy", 32'(c_rd_rdy), 0);
    end
    rd_v[1] = 1'b0;
    tick();
    chk("late idle", 32'(dut.state), 32'(IDLE));
    chk("late no_rv", 32'(mem_read_valid), 0);

    // consumer 3 asserts read and write together
    lat = 1;
    rd_a[3] = 8'h07;
    wr_a[3] = 8'h07;
    wr_d[3] = 16'hC0DE;
    rd_v[3] = 1'b1;
    wr_v[3] = 1'b1;
    run_round("rw3");
    chk("rw3 count", 32'(obs_order.size()), 2);

    // reset while waiting on a read
    lat = 5;
    rd_a[0] = 8'h30;
    rd_v[0] = 1'b1;
    tick();
    chk("rst waiting", 32'(dut.state), 32'(READ_WAITING));
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("rst_mid");
    reset = 1'b0;
    m_rr = 0;
    for (int i = 0; i < N; i++) m_last[i] = '0;
    lat = 0;
    run_round("post_rst");
    chk("post_rst who", 32'(obs_order[0]), 0);

    // randomized rounds
    for (int r = 0; r < 25; r++) begin
      lat = int'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        logic [1:0] sel;
        sel     = 2'($urandom_range(0, 3));
        rd_v[i] = sel[0];
        wr_v[i] = sel[1];
        rd_a[i] = data_memory_address_t'($urandom_range(0, 15));
        wr_a[i] = data_memory_address_t'($urandom_range(0, 15));
        wr_d[i] = data_t'($urandom);
      end
      run_round("rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_responder.md
# lsu_mem_responder

Responder side of the LSU data-memory handshake. It accepts load and store requests from `NUM_CONSUMERS` LSUs, arbitrates them round-robin onto one external data-memory port, and returns each result to the requesting LSU with a single-cycle ready pulse. It sits between the per-thread LSUs of a core and the data memory.

## Interface
Parameters:
- `NUM_CONSUMERS`, default 4: number of LSU request channels; must be ≥1.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `consumer_read_valid` in [NUM_CONSUMERS]: LSU load request.
- `consumer_read_address` in NUM_CONSUMERS × data_memory_address_t: load address.
- `consumer_read_ready` out [NUM_CONSUMERS]: load complete, one-cycle pulse.
- `consumer_read_data` out NUM_CONSUMERS × data_t: load result, valid while ready is high, then held.
- `consumer_write_valid` in [NUM_CONSUMERS]: LSU store request.
- `consumer_write_address` in NUM_CONSUMERS × data_memory_address_t: store address.
- `consumer_write_data` in NUM_CONSUMERS × data_t: store data.
- `consumer_write_ready` out [NUM_CONSUMERS]: store complete, one-cycle pulse.
- `mem_read_valid` out 1, `mem_read_address` out data_memory_address_t: downstream read request.
- `mem_read_ready` in 1, `mem_read_data` in data_t: downstream read completion and data.
- `mem_write_valid` out 1, `mem_write_address` out data_memory_address_t, `mem_write_data` out data_t: downstream write request.
- `mem_write_ready` in 1: downstream write completion.

## Operation
State machine states are `IDLE`, `READ_WAITING`, `WRITE_WAITING` and `RELAYING`. Registers are `state`, `current_consumer` and the round-robin pointer `rr_next`.

- **Reset:** state = IDLE, `rr_next` = 0, `current_consumer` = 0. All outputs are 0, including every data and address output.
- **IDLE:**
  - Scan consumers starting at `rr_next`, wrapping modulo `NUM_CONSUMERS`.
  - Grant the first consumer with `read_valid` or `write_valid` high.
  - If a consumer has both set, its read is served first. The write is served on a later grant.
  - On a read grant: set `mem_read_valid` to 1, latch `mem_read_address`, go to READ_WAITING.
  - On a write grant: set `mem_write_valid` to 1, latch `mem_write_address` and `mem_write_data`, go to WRITE_WAITING.
  - On any grant: record `current_consumer` and set `rr_next` to the granted index + 1 (mod N).
  - With no requests, stay in IDLE and hold `rr_next`.
- **READ_WAITING:** when `mem_read_ready` is high:
  - set `mem_read_valid` to 0;
  - set `consumer_read_data[cur]` to `mem_read_data`;
  - set `consumer_read_ready[cur]` to 1;
  - go to RELAYING.
- **WRITE_WAITING:** when `mem_write_ready` is high:
  - set `mem_write_valid` to 0;
  - set `consumer_write_ready[cur]` to 1;
  - go to RELAYING.
- **RELAYING:**
  - Clear every consumer ready output unconditionally, so each ready is exactly one cycle wide.
  - Stay until the served valid (read or write) of `cur` is 0, then go to IDLE.
  - This prevents re-serving an LSU that has not yet dropped its valid.
- `consumer_read_data[i]` is held until consumer i's next read completes.
- A consumer dropping valid while its request is in flight is a protocol violation. The transaction still completes and the ready pulse is still issued.
- Downstream ready arriving in IDLE or RELAYING is ignored.
- Reset in any state aborts the transaction immediately and returns all outputs to 0. The in-flight memory operation is not replayed.

## Timing
- Request valid high at edge E → `mem_*_valid` high after E (grant latency 1 cycle).
- Downstream ready sampled at edge M → consumer ready high after M; downstream valid low after M.
- Minimum load or store round trip, request edge to consumer ready, is 2 cycles with zero-wait memory.
- The LSU drops valid one cycle after seeing ready. With that behaviour, RELAYING lasts ≥1 cycle.
- Minimum back-to-back spacing between grants is 3 cycles. Only one transaction is in flight at a time.
- Round-robin fairness: with all consumers continuously requesting, each consumer is granted once per N grants.

## Structure
- Add to `common.sv`: `mem_resp_state_t` enum with IDLE, READ_WAITING, WRITE_WAITING, RELAYING.
- Reuse the existing `data_t` and `data_memory_address_t` typedefs.
- One sub-module, `rr_arbiter`:
  - inputs: request vector, advance strobe;
  - outputs: grant index and grant-valid;
  - owns `rr_next`; synchronous reset to 0.
- The rest of the FSM lives in `lsu_mem_responder`. Total size is about 200 lines.

## Test plan
- **Single load:** reset; consumer 2 reads address 0x10; memory returns 0xBEEF with ready one cycle after request.
  - `consumer_read_ready[2]` pulses for exactly 1 cycle with data 0xBEEF.
  - The grant occurs one cycle after the request.
- **Single store:** consumer 0 writes 0x1234 to address 0x05.
  - `mem_write_address` = 0x05 and `mem_write_data` = 0x1234.
  - `consumer_write_ready[0]` pulses once. No read signals toggle.
- **Round-robin:** all 4 consumers request reads at once, with a 2-cycle memory latency.
  - Grant order is 0, 1, 2, 3.
  - Re-issuing all requests gives order 0, 1, 2, 3 again, starting from `rr_next` = 0.
- **Valid held late:** consumer 1 keeps read valid high 3 cycles after its ready pulse.
  - State stays RELAYING and no second `mem_read_valid` is issued.
  - IDLE is entered one cycle after valid falls.
- **Read and write on one consumer:** consumer 3 asserts read and write together.
  - The read is served first, the write on a later grant.
  - Each is acknowledged by its own ready pulse.
- **Reset mid-operation:** assert reset during READ_WAITING.
  - Next cycle all outputs are 0 and state is IDLE.
  - A following request from consumer 0 is granted normally.
